lcd_layer_arbiter: RTL
======================

Name: lcd_layer_arbiter

Overview:
- Per-pixel compositor/arbiter between the LCD timing generator and the panel pins (HD, VD, DEN, R, G, B).
- Grants the RGB output each pixel to one of three requesters: blinking cursor, text generator, background. Fixed priority: cursor > text > background.
- Delays the sync and DEN signals to stay aligned with the composited pixel.
- Applies layer-enable configuration only at frame boundaries, so there is no tearing.

Parameters:
- H_BITS, 11, width of hcount / cur_x
- V_BITS, 10, width of vcount / cur_y
- CUR_W, 8, cursor width in pixels (1..255)
- CUR_H, 16, cursor height in pixels (1..255)
- BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; the pipeline advances only when high
- HD_in  in  1  horizontal sync from timing generator, active low
- VD_in  in  1  vertical sync from timing generator, active low
- DEN_in  in  1  active-area flag from timing generator
- hcount  in  H_BITS  current pixel column
- vcount  in  V_BITS  current pixel row
- bg_rgb  in  24  background colour {R,G,B}
- txt_req  in  1  text layer has an opaque pixel here
- txt_rgb  in  24  text pixel colour
- cur_x  in  H_BITS  cursor left column
- cur_y  in  V_BITS  cursor top row
- cur_rgb  in  24  cursor colour
- cfg_we  in  1  write strobe for cfg_mask (any CLK cycle)
- cfg_mask  in  3  layer enables {cursor, text, background}
- HD  out  1  aligned HD
- VD  out  1  aligned VD
- DEN  out  1  aligned DEN
- R  out  8  red
- G  out  8  green
- B  out  8  blue
- grant  out  2  layer that won: 0 none, 1 bg, 2 text, 3 cursor
- blink  out  1  current cursor blink phase

Behaviour:
- Reset: all outputs and internal registers go to 0, except the following.
  - HD and VD go to 1 (inactive).
  - blink goes to 1.
  - Active and pending masks go to 3'b111.
  - FSM goes to WAIT_SYNC.
  - Blink counter goes to 0.
- Reset asserted mid-frame returns to this same state immediately.
- Pipeline: 2 stages, both clocked on CLK with pix_en.
  - Stage 1 registers the inputs and computes cursor_hit: cur_x <= hcount <= cur_x+CUR_W-1 and cur_y <= vcount <= cur_y+CUR_H-1.
  - The sums are computed one bit wider, so a cursor near the right or bottom edge clips and never wraps.
  - Stage 2 does the priority mux and registers the outputs.
  - Latency: exactly 2 pix_en strobes from inputs to HD/VD/DEN/R/G/B/grant.
  - When pix_en = 0, all registers hold.
- Frame start = falling edge of VD_in: previous sampled value 1, current value 0, sampled on pix_en cycles only.
- FSM:
  - WAIT_SYNC: HD and VD propagate through the pipeline; DEN forced 0; RGB forced 0; grant forced 0. On frame start, go to RUN.
  - RUN: normal compositing. No exit except reset.
- Arbitration in stage 2, only when delayed DEN = 1:
  - If cursor_hit & mask[2] & blink: grant 3, output cur_rgb.
  - Else if txt_req & mask[1]: grant 2, output txt_rgb.
  - Else if mask[0]: grant 1, output bg_rgb.
  - Else: grant 0, output black.
  - When delayed DEN = 0: RGB = 0 and grant = 0.
- Config:
  - cfg_we loads the pending mask on any CLK cycle.
  - The active mask is copied from the pending mask at each frame start in RUN, and at the WAIT_SYNC to RUN transition.
  - If cfg_we coincides with a frame-start cycle, the new value is taken directly into the active mask at that frame start.
- Blink:
  - At each frame start in RUN, the counter increments.
  - When it reaches BLINK_FRAMES-1, it wraps to 0 and blink toggles.
  - With BLINK_FRAMES = 1, blink toggles every frame.

Optional Feature:
- Macro: LCD_GRID_OVERLAY_EN.
- Defined:
  - A debug grid is drawn when hcount[4:0] == 0 or vcount[4:0] == 0 (every 32 px).
  - Colour is 24'hFFFFFF, grant = 1.
  - Priority: below text, above background.
  - Gated by mask[0].
- Undefined: no grid logic; behaviour exactly as above.

Decomposition:
- Shared package lcd_pkg holds:
  - grant encodings GNT_NONE/BG/TXT/CUR;
  - FSM state constants WAIT_SYNC/RUN;
  - RGB_BLACK and RGB_WHITE;
  - default panel timing constants (800x480 active).
- One natural sub-module: lcd_blink_ctr. It takes the frame-start pulse and outputs blink, parameterised by BLINK_FRAMES.

Test Plan:
1. Reset for 20 clocks, release, drive a full 800x480 frame with bg_rgb = 24'h0000FF, txt_req = 0 -> DEN/RGB stay 0 until the first VD_in fall. From the second frame: every active pixel is R=0, G=0, B=FF, grant = 1, and HD/VD equal the inputs delayed by exactly 2 pix_en strobes.
2. cur_x = 100, cur_y = 50, CUR_W = 8, CUR_H = 16, txt_req = 1 everywhere -> grant = 3 only for hcount 100..107 and vcount 50..65, grant = 2 elsewhere. cur_x = 796 -> cursor clipped to 796..799 with no wrap to column 0.
3. BLINK_FRAMES = 2 -> blink sequence 1,1,0,0,1 across frame starts. Cursor pixels show text/bg colour in the frames where blink = 0.
4. cfg_we with mask 3'b010 at mid-frame line 200 -> the rest of that frame is unchanged. Next frame: non-text pixels are black with grant = 0. cfg_we coincident with the frame-start cycle takes effect in that same frame.
5. pix_en toggling 1/0 (NCLK = CLK/2) -> outputs change only on pix_en cycles. RST_n pulled low mid-frame -> HD = VD = 1, DEN = 0, RGB = 0 asynchronously, then WAIT_SYNC behaviour as in scenario 1.
6. With LCD_GRID_OVERLAY_EN, txt_req = 0 -> pixels at hcount 0, 32, 64 are FFFFFF with grant = 1. With txt_req = 1 at hcount 32 -> text wins.

Source files
------------

// File: rtl/lcd_layer_arbiter_pkg.sv
// Shared types and constants for the LCD layer arbiter.
// Includes the grid helper used only when LCD_GRID_OVERLAY_EN is defined.
package lcd_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_BG   = 2'd1,
    GNT_TXT  = 2'd2,
    GNT_CUR  = 2'd3
  } grant_e;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_e;

  localparam logic [23:0] RGB_BLACK = '0;
  localparam logic [23:0] RGB_WHITE = '1;

  // Default 800x480 panel timing (active area plus typical totals).
  localparam int unsigned LCD_H_ACTIVE = 800;
  localparam int unsigned LCD_V_ACTIVE = 480;
  localparam int unsigned LCD_H_TOTAL  = 1056;
  localparam int unsigned LCD_V_TOTAL  = 525;

  // Stage-1 pixel payload carried to the priority mux.
  typedef struct packed {
    logic        den;
    logic        txt_req;
    logic [23:0] bg_rgb;
    logic [23:0] txt_rgb;
    logic [23:0] cur_rgb;
    logic        hit;
  } s1_pix_t;

  function automatic logic on_grid(input logic [4:0] h_lo, input logic [4:0] v_lo);
    return (h_lo == '0) || (v_lo == '0);
  endfunction

endpackage

// File: rtl/lcd_layer_arbiter_blink_ctr.sv
// Cursor blink phase generator: toggles o_blink every BLINK_FRAMES frame starts.
module lcd_blink_ctr #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic i_frame_start,
  output logic o_blink
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_blink;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt   <= '0;
      r_blink <= 1'b1;
    end else if (i_frame_start) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/lcd_layer_arbiter.sv
// Per-pixel cursor/text/background compositor with 2-stage aligned sync path.
// Optional debug grid overlay enabled by defining LCD_GRID_OVERLAY_EN.
module lcd_layer_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned H_BITS       = 11,
  parameter int unsigned V_BITS       = 10,
  parameter int unsigned CUR_W        = 8,
  parameter int unsigned CUR_H        = 16,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              pix_en,
  input  logic              HD_in,
  input  logic              VD_in,
  input  logic              DEN_in,
  input  logic [H_BITS-1:0] hcount,
  input  logic [V_BITS-1:0] vcount,
  input  logic [23:0]       bg_rgb,
  input  logic              txt_req,
  input  logic [23:0]       txt_rgb,
  input  logic [H_BITS-1:0] cur_x,
  input  logic [V_BITS-1:0] cur_y,
  input  logic [23:0]       cur_rgb,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_mask,
  output logic              HD,
  output logic              VD,
  output logic              DEN,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic [1:0]        grant,
  output logic              blink
);

  localparam logic [H_BITS:0] X_SPAN = (H_BITS + 1)'(CUR_W - 1);
  localparam logic [V_BITS:0] Y_SPAN = (V_BITS + 1)'(CUR_H - 1);

  state_e     r_state;
  logic       r_vd_prev;
  logic [2:0] r_mask_pend;
  logic [2:0] r_mask_act;

  logic       w_frame_start;
  logic       w_blink;

  logic       r_s1_hd;
  logic       r_s1_vd;
  s1_pix_t    r_s1;

  logic       r_hd;
  logic       r_vd;
  logic       r_den;
  logic [23:0] r_rgb;
  grant_e     r_grant;

  logic [H_BITS:0] w_x_end;
  logic [V_BITS:0] w_y_end;
  logic            w_hit;
  logic [23:0]     w_rgb;
  grant_e          w_gnt;

  assign w_frame_start = pix_en & r_vd_prev & ~VD_in;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_vd_prev <= 1'b0;
    end else if (pix_en) begin
      r_vd_prev <= VD_in;
    end
  end

  // A cfg_we landing on the frame-start cycle bypasses the pending register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state     <= WAIT_SYNC;
      r_mask_pend <= '1;
      r_mask_act  <= '1;
    end else begin
      if (cfg_we) begin
        r_mask_pend <= cfg_mask;
      end
      if (w_frame_start) begin
        r_mask_act <= cfg_we ? cfg_mask : r_mask_pend;
      end
      case (r_state)
        WAIT_SYNC: if (w_frame_start) r_state <= RUN;
        RUN:       r_state <= RUN;
        default:   r_state <= WAIT_SYNC;
      endcase
    end
  end

  lcd_blink_ctr #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .i_frame_start(w_frame_start & (r_state == RUN)),
    .o_blink      (w_blink)
  );

  // One extra bit keeps the window end from wrapping past the last column/row.
  assign w_x_end = {1'b0, cur_x} + X_SPAN;
  assign w_y_end = {1'b0, cur_y} + Y_SPAN;
  assign w_hit   = (hcount >= cur_x) && ({1'b0, hcount} <= w_x_end) &&
                   (vcount >= cur_y) && ({1'b0, vcount} <= w_y_end);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1_hd <= 1'b1;
      r_s1_vd <= 1'b1;
      r_s1    <= '0;
    end else if (pix_en) begin
      r_s1_hd      <= HD_in;
      r_s1_vd      <= VD_in;
      r_s1.den     <= DEN_in;
      r_s1.txt_req <= txt_req;
      r_s1.bg_rgb  <= bg_rgb;
      r_s1.txt_rgb <= txt_rgb;
      r_s1.cur_rgb <= cur_rgb;
      r_s1.hit     <= w_hit;
    end
  end

`ifdef LCD_GRID_OVERLAY_EN
  logic r_s1_grid;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_s1_grid <= 1'b0;
    end else if (pix_en) begin
      r_s1_grid <= on_grid(hcount[4:0], vcount[4:0]);
    end
  end
`endif

  always_comb begin
    w_rgb = RGB_BLACK;
    w_gnt = GNT_NONE;
    if ((r_state == RUN) && r_s1.den) begin
      if (r_s1.hit && r_mask_act[2] && w_blink) begin
        w_rgb = r_s1.cur_rgb;
        w_gnt = GNT_CUR;
      end else if (r_s1.txt_req && r_mask_act[1]) begin
        w_rgb = r_s1.txt_rgb;
        w_gnt = GNT_TXT;
`ifdef LCD_GRID_OVERLAY_EN
      end else if (r_s1_grid && r_mask_act[0]) begin
        w_rgb = RGB_WHITE;
        w_gnt = GNT_BG;
`endif
      end else if (r_mask_act[0]) begin
        w_rgb = r_s1.bg_rgb;
        w_gnt = GNT_BG;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_hd    <= 1'b1;
      r_vd    <= 1'b1;
      r_den   <= 1'b0;
      r_rgb   <= RGB_BLACK;
      r_grant <= GNT_NONE;
    end else if (pix_en) begin
      r_hd    <= r_s1_hd;
      r_vd    <= r_s1_vd;
      r_den   <= r_s1.den & (r_state == RUN);
      r_rgb   <= w_rgb;
      r_grant <= w_gnt;
    end
  end

  assign HD    = r_hd;
  assign VD    = r_vd;
  assign DEN   = r_den;
  assign R     = r_rgb[23:16];
  assign G     = r_rgb[15:8];
  assign B     = r_rgb[7:0];
  assign grant = r_grant;
  assign blink = w_blink;

endmodule
